scb_wb_collector: RTL and testbench
===================================

# scb_wb_collector

Writeback collector directly downstream of the scoreboard cell array. Each scoreboard cell presents its writeback candidate `{ready, pip, rd}` for exactly one cycle before it retires itself. This block captures every ready candidate in that cycle into a per-slot pending store, then drains them one at a time to the register-file write port. The drain uses round-robin order over a valid/ready handshake, so no completion is lost when several cells finish together.

## Interface
Parameters:
- `N_CELL`, 8, number of scoreboard cells (slots); power of two, at least 2.
- `W_pip`, 1, pipeline-tag width.
- `W_PA_rx`, 5, destination-register address width.
- `W_ident`, 4, slot-identifier width; the msb is a dump bit, so `W_ident` is at least clog2(`N_CELL`)+1.
- `W_CAND`, 1+`W_pip`+`W_PA_rx`, width of one candidate (derived).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `candit_wb`  in  `N_CELL`*`W_CAND`  concatenated cell candidates. Slot k occupies bits [k*`W_CAND` +: `W_CAND`], ordered `{ready, pip, rd}` with ready as the msb.
- `CFI_PC_clear`  in  1  control-flow flush.
- `wb_ready`  in  1  write port accepts this cycle.
- `wb_valid`  out  1  output record valid.
- `wb_pip`  out  `W_pip`  tag of the output record.
- `wb_rd`  out  `W_PA_rx`  destination of the output record.
- `wb_slot`  out  `W_ident`  originating slot, with the msb forced to 0.
- `pend_mask`  out  `N_CELL`  per-slot pending bits, used for hazard snoop.
- `pend_cnt`  out  clog2(`N_CELL`+1)  popcount of `pend_mask`.
- `ovf`  out  1  sticky overflow error.

## Operation
- Per slot k, the block stores `pend[k]`, `pip_q[k]` and `rd_q[k]`.
- **Capture.** When `ready_k` is 1 on an edge:
  - `pend[k]` is set to 1.
  - `pip_q[k]` and `rd_q[k]` are loaded from the candidate.
  - The bypass exception is in Configuration.
- **Arbitration.** The request vector is `pend`. The grant goes to the first set bit found when searching from `rr_ptr` upward, modulo `N_CELL`.
- **Load enable.** `load = !wb_valid || wb_ready`. When `load` is asserted and the request vector is nonzero:
  - The output register takes the granted slot's fields, and `wb_valid` is set to 1.
  - `pend[grant]` is cleared.
  - `rr_ptr` is set to (grant+1) mod `N_CELL`.
- **Idle output.** When `load` is asserted and no slot requests, `wb_valid` is set to 0.
- **Stall.** While `wb_valid` is 1 and `wb_ready` is 0, `wb_pip`, `wb_rd` and `wb_slot` are held stable.
- **Same-slot collision.** If the same slot is drained and captured on the same edge, the capture wins: `pend[k]` stays 1 and holds the new data.
- **Overflow.**
  - Condition: a capture hits slot k while `pend[k]` is 1 and slot k is not drained on that edge.
  - Effect: `ovf` is set to 1 and the new data overwrites the old.
  - `ovf` is cleared only by `rst_n`.
- **Flush.** `CFI_PC_clear` takes priority over capture and drain:
  - On that edge, all `pend` bits clear and `wb_valid` clears.
  - Candidates presented in that cycle are discarded.
  - `rr_ptr` and `ovf` are preserved.
- **Reset values.** `wb_valid`=0, `wb_pip`=0, `wb_rd`=0, `wb_slot`=0, `pend_mask`=0, `pend_cnt`=0, `ovf`=0, `rr_ptr`=0, all `pip_q`/`rd_q` entries=0.

## Timing
- **Latency without bypass.** A candidate ready in cycle N is pending in cycle N+1. With the output free, `wb_valid` is asserted in cycle N+2.
- **Throughput.** One record per cycle while `wb_ready` is held at 1.
- **Update timing.** `pend_mask` and `pend_cnt` are registered-state views; they update in the cycle after a capture or drain.
- **Fairness.** Round-robin guarantees a pending slot is granted within `N_CELL` loads.
- **Reset.** Asserting `rst_n` mid-transfer drops the output record immediately, asynchronously. The first capture after deassertion is taken on the next edge.

## Configuration
- Macro: `SCB_WB_BYPASS_EN`.
- **Defined.** The request vector is `pend | ready`.
  - Ready candidates of the current cycle take part in arbitration on the same edge.
  - A granted non-pending candidate loads the output directly and never sets `pend`.
  - Latency becomes 1: ready in cycle N gives `wb_valid` in cycle N+1.
  - Same-slot priority: if `pend[k]` and `ready_k` are both 1 and slot k is granted, the old pending data is output and the new data stays pending.
- **Undefined.** The request vector is `pend` only, with latency 2 as in Timing.

## Test plan
- **Single completion.** Slot 3 ready with rd=5'd7 and pip=1 in cycle 0, `wb_ready`=1 → `wb_valid` in cycle 2 (cycle 1 with bypass), `wb_rd`=7, `wb_slot`=4'd3, then `pend_cnt` returns to 0.
- **Burst fairness.** Slots 0, 2 and 5 ready in the same cycle with `rr_ptr`=3 → output order 5, 0, 2 on consecutive cycles; `pend_cnt` goes 3→2→1→0.
- **Backpressure.** `wb_ready` held at 0 for 4 cycles with slots 1 and 6 pending → outputs held stable on slot 1; after `wb_ready`=1, slot 1 then slot 6 are delivered.
- **Overflow.** Hold `wb_ready`=0 with slot 4 pending (rd=9), then recapture slot 4 with rd=12 → `ovf`=1; drained record has rd=12.
- **Flush.** `CFI_PC_clear` in a cycle with 3 slots pending and slot 2 ready → next cycle `pend_mask`=0 and `wb_valid`=0; `ovf` unchanged.
- **Async reset.** `rst_n` low mid-burst → all outputs 0 immediately; after release, a fresh capture in slot 0 is delivered with normal latency.

Source files
------------

// File: rtl/scb_wb_collector_if.sv
// rtl/scb_wb_collector_if.sv - register-file writeback port between collector (master) and write port (slave)
interface scb_wb_collector_if #(
    parameter int W_pip   = 1,
    parameter int W_PA_rx = 5,
    parameter int W_ident = 4
);
    logic               wb_valid;
    logic               wb_ready;
    logic [W_pip-1:0]   wb_pip;
    logic [W_PA_rx-1:0] wb_rd;
    logic [W_ident-1:0] wb_slot;

    modport master (output wb_valid, output wb_pip, output wb_rd, output wb_slot, input wb_ready);
    modport slave  (input wb_valid, input wb_pip, input wb_rd, input wb_slot, output wb_ready);
endinterface

// File: rtl/scb_wb_collector.sv
// rtl/scb_wb_collector.sv - scoreboard writeback collector: per-slot pending store, round-robin drain
// Optional same-cycle bypass of ready candidates into arbitration: SCB_WB_BYPASS_EN
module scb_wb_collector #(
    parameter int N_CELL  = 8,
    parameter int W_pip   = 1,
    parameter int W_PA_rx = 5,
    parameter int W_ident = 4,
    parameter int W_CAND  = 1 + W_pip + W_PA_rx
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_CELL*W_CAND-1:0]     candit_wb,
    input  logic                         CFI_PC_clear,
    scb_wb_collector_if.master           wb,
    output logic [N_CELL-1:0]            pend_mask,
    output logic [$clog2(N_CELL+1)-1:0]  pend_cnt,
    output logic                         ovf
);
    localparam int PW = $clog2(N_CELL);
    localparam int CW = $clog2(N_CELL+1);

    logic [N_CELL-1:0]              rdy, pend, req, drn, cap;
    logic [N_CELL-1:0][W_pip-1:0]   c_pip, pip_q;
    logic [N_CELL-1:0][W_PA_rx-1:0] c_rd, rd_q;
    logic [PW-1:0]                  rr_ptr, gnt, idx;
    logic                           gnt_vld, load, drain;
    logic [W_pip-1:0]               sel_pip;
    logic [W_PA_rx-1:0]             sel_rd;

    for (genvar k = 0; k < N_CELL; k++) begin : g_unpack
        assign rdy[k]   = candit_wb[k*W_CAND + W_CAND - 1];
        assign c_pip[k] = candit_wb[k*W_CAND + W_PA_rx +: W_pip];
        assign c_rd[k]  = candit_wb[k*W_CAND +: W_PA_rx];
    end

    assign load  = !wb.wb_valid || wb.wb_ready;
    assign drain = load && gnt_vld;
    assign drn   = drain ? (N_CELL'(1) << gnt) : '0;

`ifdef SCB_WB_BYPASS_EN
    // A granted slot that was not pending goes straight to the output and is never stored
    assign req = pend | rdy;
    assign cap = rdy & ~(drn & ~pend);
`else
    assign req = pend;
    assign cap = rdy;
`endif

    // Scan from the farthest offset down so the nearest request at or after rr_ptr wins
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = N_CELL - 1; i >= 0; i--) begin
            idx = rr_ptr + PW'(i);
            if (req[idx]) begin
                gnt     = idx;
                gnt_vld = 1'b1;
            end
        end
    end

    assign sel_pip = pend[gnt] ? pip_q[gnt] : c_pip[gnt];
    assign sel_rd  = pend[gnt] ? rd_q[gnt]  : c_rd[gnt];

    always_comb begin
        pend_cnt = '0;
        for (int k = 0; k < N_CELL; k++) begin
            pend_cnt = pend_cnt + CW'(pend[k]);
        end
    end

    assign pend_mask = pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= '0;
            pip_q       <= '0;
            rd_q        <= '0;
            rr_ptr      <= '0;
            ovf         <= 1'b0;
            wb.wb_valid <= 1'b0;
            wb.wb_pip   <= '0;
            wb.wb_rd    <= '0;
            wb.wb_slot  <= '0;
        end else if (CFI_PC_clear) begin
            pend        <= '0;
            wb.wb_valid <= 1'b0;
        end else begin
            if (load) begin
                wb.wb_valid <= gnt_vld;
                if (gnt_vld) begin
                    wb.wb_pip  <= sel_pip;
                    wb.wb_rd   <= sel_rd;
                    wb.wb_slot <= W_ident'(gnt);
                    rr_ptr     <= gnt + 1'b1;
                end
            end
            // Capture beats drain on the same slot; capturing over an undrained entry is an overflow
            for (int k = 0; k < N_CELL; k++) begin
                if (cap[k]) begin
                    pend[k]  <= 1'b1;
                    pip_q[k] <= c_pip[k];
                    rd_q[k]  <= c_rd[k];
                end else if (drn[k]) begin
                    pend[k]  <= 1'b0;
                end
            end
            if (|(cap & pend & ~drn)) begin
                ovf <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_scb_wb_collector.sv
// tb/tb_scb_wb_collector.sv - directed and random checks of scb_wb_collector against a reference model
module tb_scb_wb_collector;
    localparam int N  = 8;
    localparam int WP = 1;
    localparam int WR = 5;
    localparam int WI = 4;
    localparam int WC = 1 + WP + WR;
`ifdef SCB_WB_BYPASS_EN
    localparam int LAT = 1;
    localparam bit BYP = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit BYP = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [N*WC-1:0]          candit_wb;
    logic                     CFI_PC_clear;
    logic [N-1:0]             pend_mask;
    logic [$clog2(N+1)-1:0]   pend_cnt;
    logic                     ovf;

    scb_wb_collector_if #(.W_pip(WP), .W_PA_rx(WR), .W_ident(WI)) wb_if ();

    scb_wb_collector #(.N_CELL(N), .W_pip(WP), .W_PA_rx(WR), .W_ident(WI)) dut (
        .clk(clk), .rst_n(rst_n), .candit_wb(candit_wb), .CFI_PC_clear(CFI_PC_clear),
        .wb(wb_if), .pend_mask(pend_mask), .pend_cnt(pend_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // stimulus for the coming edge
    bit             t_rdy[N];
    logic [WP-1:0]  t_pip[N];
    logic [WR-1:0]  t_rd[N];
    bit             t_clr;
    bit             t_wbr;

    // reference model state
    bit             m_pend[N];
    logic [WP-1:0]  m_pip[N];
    logic [WR-1:0]  m_rd[N];
    int             m_rr;
    bit             m_valid, m_ovf;
    logic [WP-1:0]  m_opip;
    logic [WR-1:0]  m_ord;
    int             m_oslot;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_pend[k] = 0; m_pip[k] = '0; m_rd[k] = '0;
        end
        m_rr = 0; m_valid = 0; m_ovf = 0; m_opip = '0; m_ord = '0; m_oslot = 0;
    endfunction

    function automatic void model_edge();
        bit old_pend[N];
        int g;
        if (t_clr) begin
            for (int k = 0; k < N; k++) m_pend[k] = 0;
            m_valid = 0;
            return;
        end
        old_pend = m_pend;
        g = -1;
        if (!m_valid || t_wbr) begin
            for (int i = 0; i < N; i++) begin
                int k;
                k = (m_rr + i) % N;
                if (g < 0 && (m_pend[k] || (BYP && t_rdy[k]))) g = k;
            end
            if (g >= 0) begin
                if (m_pend[g]) begin m_opip = m_pip[g]; m_ord = m_rd[g]; end
                else           begin m_opip = t_pip[g]; m_ord = t_rd[g]; end
                m_valid = 1; m_oslot = g; m_rr = (g + 1) % N; m_pend[g] = 0;
            end else begin
                m_valid = 0;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (t_rdy[k] && !(k == g && !old_pend[k])) begin
                if (old_pend[k] && k != g) m_ovf = 1;
                m_pend[k] = 1; m_pip[k] = t_pip[k]; m_rd[k] = t_rd[k];
            end
        end
    endfunction

    task automatic compare();
        logic [N-1:0] mk;
        int cnt;
        cnt = 0;
        for (int k = 0; k < N; k++) begin
            mk[k] = m_pend[k];
            cnt += int'(m_pend[k]);
        end
        chk("wb_valid", wb_if.wb_valid, m_valid);
        chk("pend_mask", pend_mask, mk);
        chk("pend_cnt", pend_cnt, cnt);
        chk("ovf", ovf, m_ovf);
        if (m_valid) begin
            chk("wb_pip", wb_if.wb_pip, m_opip);
            chk("wb_rd", wb_if.wb_rd, m_ord);
            chk("wb_slot", wb_if.wb_slot, m_oslot);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) candit_wb[k*WC +: WC] = {t_rdy[k], t_pip[k], t_rd[k]};
        CFI_PC_clear   = t_clr;
        wb_if.wb_ready = t_wbr;
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_edge();
        #1;
        compare();
        for (int k = 0; k < N; k++) t_rdy[k] = 0;
        t_clr = 0;
    endtask

    task automatic cap(int k, logic [WP-1:0] p, logic [WR-1:0] r);
        t_rdy[k] = 1; t_pip[k] = p; t_rd[k] = r;
    endtask

    int got[$];
    int exp_order[3] = '{5, 0, 2};

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < N; k++) begin t_rdy[k] = 0; t_pip[k] = '0; t_rd[k] = '0; end
        t_clr = 0; t_wbr = 0;
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", wb_if.wb_valid, 0);
        chk("rst_rd", wb_if.wb_rd, 0);
        chk("rst_slot", wb_if.wb_slot, 0);
        chk("rst_pend_mask", pend_mask, 0);
        chk("rst_pend_cnt", pend_cnt, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        // backpressure: slot 1 held while stalled, then slot 1 and slot 6 delivered
        t_wbr = 0;
        cap(1, 1'b0, 5'd3); cap(6, 1'b1, 5'd11);
        repeat (LAT) step();
        chk("bp_first_slot", wb_if.wb_slot, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_valid", wb_if.wb_valid, 1);
            chk("bp_hold_slot", wb_if.wb_slot, 1);
            chk("bp_hold_rd", wb_if.wb_rd, 3);
        end
        t_wbr = 1;
        step();
        chk("bp_second_slot", wb_if.wb_slot, 6);
        step();
        chk("bp_drained", wb_if.wb_valid, 0);

        // single completion
        cap(3, 1'b1, 5'd7);
        repeat (LAT) step();
        chk("single_valid", wb_if.wb_valid, 1);
        chk("single_rd", wb_if.wb_rd, 7);
        chk("single_slot", wb_if.wb_slot, 3);
        step();
        chk("single_cnt_after", pend_cnt, 0);

        // move rr_ptr to 3, then burst of slots 0, 2, 5
        cap(2, 1'b0, 5'd1);
        repeat (LAT + 1) step();
        cap(0, 1'b0, 5'd20); cap(2, 1'b1, 5'd22); cap(5, 1'b0, 5'd25);
        for (int i = 0; i < 6; i++) begin
            step();
            if (wb_if.wb_valid) got.push_back(int'(wb_if.wb_slot));
        end
        chk("burst_count", got.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("burst_order", (i < got.size()) ? got[i] : -1, exp_order[i]);

        // overflow on slot 4 while the output is stalled
        t_wbr = 0;
        cap(0, 1'b0, 5'd1); step();
        cap(4, 1'b0, 5'd9); step();
        cap(4, 1'b1, 5'd12); step();
        chk("ovf_set", ovf, 1);
        t_wbr = 1;
        step();
        chk("ovf_slot", wb_if.wb_slot, 4);
        chk("ovf_rd", wb_if.wb_rd, 12);
        step();

        // flush with three pending and slot 2 ready
        t_wbr = 0;
        cap(7, 1'b0, 5'd2); step();
        cap(1, 1'b0, 5'd4); cap(3, 1'b1, 5'd6); cap(5, 1'b0, 5'd8); step();
        chk("flush_pre_cnt", pend_cnt, 3);
        t_clr = 1; cap(2, 1'b1, 5'd30);
        step();
        chk("flush_mask", pend_mask, 0);
        chk("flush_valid", wb_if.wb_valid, 0);
        chk("flush_ovf", ovf, 1);
        t_wbr = 1;
        step();
        chk("flush_discard", wb_if.wb_valid, 0);

        // asynchronous reset mid-burst
        cap(0, 1'b1, 5'd10); cap(1, 1'b0, 5'd11); cap(2, 1'b1, 5'd12); cap(3, 1'b0, 5'd13);
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", wb_if.wb_valid, 0);
        chk("arst_pip", wb_if.wb_pip, 0);
        chk("arst_rd", wb_if.wb_rd, 0);
        chk("arst_slot", wb_if.wb_slot, 0);
        chk("arst_mask", pend_mask, 0);
        chk("arst_cnt", pend_cnt, 0);
        chk("arst_ovf", ovf, 0);
        model_reset();
        #2 rst_n = 1'b1;
        cap(0, 1'b1, 5'd21);
        repeat (LAT) step();
        chk("arst_fresh_valid", wb_if.wb_valid, 1);
        chk("arst_fresh_slot", wb_if.wb_slot, 0);
        chk("arst_fresh_rd", wb_if.wb_rd, 21);

        // randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(3) == 0) cap(k, WP'($urandom), WR'($urandom));
            t_wbr = ($urandom_range(3) != 0);
            t_clr = ($urandom_range(31) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
